pid_multichannel_ctrl: RTL

//  N-channel time-multiplexed PID motor controller with P, I and D terms. One shared signed multiplier is

---
 rtl/motor_control_pkg.sv | 40 ++++
 rtl/control_tick_gen.sv | 21 ++
 rtl/pid_multichannel_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/motor_control_pkg.sv
// Shared definitions for the multichannel PID controller: modes, scan states, saturation helpers.
package motor_control_pkg;

   localparam logic [7:0] MODE_OFF      = 8'd0;
   localparam logic [7:0] MODE_POSITION = 8'd1;
   localparam logic [7:0] MODE_VELOCITY = 8'd2;
   localparam logic [7:0] MODE_DIRECT   = 8'd3;

   typedef enum logic [3:0] {
      ST_IDLE, ST_LOAD, ST_ERR, ST_MUL_P, ST_MUL_I, ST_MUL_D, ST_SUM, ST_WRITE, ST_DONE
   } state_e;

   // Wide signed container; every intermediate of a WIDTH<=31 datapath fits without loss.
   typedef logic signed [63:0] calc_t;

   function automatic calc_t sat_w(input calc_t v, input int w);
      calc_t hi;
      calc_t lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)      sat_w = hi;
      else if (v < lo) sat_w = lo;
      else             sat_w = v;
   endfunction

   function automatic calc_t clamp_lim(input calc_t v, input calc_t lim);
      if (v > lim)       clamp_lim = lim;
      else if (v < -lim) clamp_lim = -lim;
      else               clamp_lim = v;
   endfunction

   function automatic logic is_pid(input logic [7:0] m);
      is_pid = (m == MODE_POSITION) || (m == MODE_VELOCITY);
   endfunction

   function automatic logic is_off(input logic [7:0] m);
      is_off = (m == MODE_OFF) || ((m != MODE_DIRECT) && !is_pid(m));
   endfunction

endpackage

// File: rtl/control_tick_gen.sv
// Free-running divider producing the one-cycle control tick on each counter wrap.
module control_tick_gen #(
   parameter int TICK_DIV = 16000
) (
   input  logic CLK,
   input  logic reset_n,
   output logic tick_o
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(TICK_DIV - 1));
   assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pid_multichannel_ctrl.sv
// Time-multiplexed PID controller: one shared signed multiplier walks every channel once per tick.
module pid_multichannel_ctrl
   import motor_control_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int WIDTH      = 24,
   parameter int CLOCK_FREQ = 16_000_000,
   parameter int CTRL_FREQ  = 1000,
   parameter int ERR_SHIFT  = 4
) (
   input  logic                    CLK,
   input  logic                    reset_n,
   input  logic [N_CH*WIDTH-1:0]   setpoint,
   input  logic [N_CH*WIDTH-1:0]   state,
   input  logic [N_CH*WIDTH-1:0]   Kp,
   input  logic [N_CH*WIDTH-1:0]   Ki,
   input  logic [N_CH*WIDTH-1:0]   Kd,
   input  logic [N_CH*WIDTH-1:0]   PWMLimit,
   input  logic [N_CH*WIDTH-1:0]   IntegralLimit,
   input  logic [N_CH*WIDTH-1:0]   deadband,
   input  logic [N_CH*8-1:0]       control_mode,
   output logic [N_CH*WIDTH-1:0]   duty,
   output logic                    update_done,
   output logic                    overrun
);
   localparam int TICK_DIV = CLOCK_FREQ / CTRL_FREQ;
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PW       = 2 * WIDTH;
   localparam int ACC_W    = 2 * WIDTH + 2;

   logic tick;
   control_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.CLK(CLK), .reset_n(reset_n), .tick_o(tick));

   state_e state_q, state_d;
   logic [CH_W-1:0] ch_q;
   logic last_ch;
   assign last_ch = (ch_q == CH_W'(N_CH - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (tick) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_ERR;
         ST_ERR:   state_d = ST_MUL_P;
         ST_MUL_P: state_d = ST_MUL_I;
         ST_MUL_I: state_d = ST_MUL_D;
         ST_MUL_D: state_d = ST_SUM;
         ST_SUM:   state_d = ST_WRITE;
         ST_WRITE: state_d = last_ch ? ST_DONE : ST_LOAD;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Per-channel working copy captured at LOAD
   logic signed [WIDTH-1:0] sp_q, st_q, kp_q, ki_q, kd_q, pl_q, il_q, db_q;
   logic [7:0]              mode_q;
   logic signed [WIDTH-1:0] int_cur_q, ep_cur_q, err_q, int_new_q, deriv_q, dnew_q;
   logic                    fresh_q;
   logic signed [ACC_W-1:0] acc_q;

   logic signed [WIDTH-1:0] integ_q [N_CH];
   logic signed [WIDTH-1:0] eprev_q [N_CH];
   logic [7:0]              pmode_q [N_CH];
   logic [N_CH*WIDTH-1:0]   duty_q;
   logic                    done_q, ovr_q;

   logic [7:0] mode_in;
   logic       keep_in;
   assign mode_in = control_mode[int'(ch_q)*8 +: 8];
   assign keep_in = is_pid(mode_in) && (mode_in == pmode_q[ch_q]);

   logic signed [WIDTH:0] e_raw;
   calc_t err_c, int_new_c, deriv_c, sum_c, abs_c, dnew_c;
   assign e_raw = {sp_q[WIDTH-1], sp_q} - {st_q[WIDTH-1], st_q};

   always_comb begin
      err_c     = sat_w(calc_t'(e_raw) >>> ERR_SHIFT, WIDTH);
      int_new_c = clamp_lim(calc_t'(int_cur_q) + calc_t'(err_q), calc_t'(il_q));
      // A freshly (re)entered PID mode has no valid history, so the D term starts at zero.
      deriv_c   = fresh_q ? '0 : sat_w(calc_t'(err_q) - calc_t'(ep_cur_q), WIDTH);
      sum_c     = calc_t'(acc_q);
      abs_c     = (sum_c < 0) ? -sum_c : sum_c;
      dnew_c    = '0;
      if (is_pid(mode_q))
         dnew_c = (abs_c <= calc_t'(db_q)) ? '0 : clamp_lim(sum_c, calc_t'(pl_q));
      else if (mode_q == MODE_DIRECT)
         dnew_c = clamp_lim(calc_t'(sp_q), calc_t'(pl_q));
      else if (is_off(mode_q))
         dnew_c = '0;
   end

   // Single shared multiplier, operands steered by scan phase
   logic signed [WIDTH-1:0] mul_a, mul_b;
   logic signed [PW-1:0]    a_ext, b_ext, prod;
   always_comb begin
      mul_a = kp_q;
      mul_b = err_q;
      case (state_q)
         ST_MUL_I: begin mul_a = ki_q; mul_b = int_new_q; end
         ST_MUL_D: begin mul_a = kd_q; mul_b = deriv_q;   end
         default:  ;
      endcase
   end
   assign a_ext = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
   assign b_ext = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
   assign prod  = a_ext * b_ext;

   logic signed [ACC_W-1:0] prod_ext;
   assign prod_ext = {{2{prod[PW-1]}}, prod};

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         ch_q <= '0;
         {sp_q, st_q, kp_q, ki_q, kd_q, pl_q, il_q, db_q} <= '0;
         mode_q <= '0;
         {int_cur_q, ep_cur_q, err_q, int_new_q, deriv_q, dnew_q} <= '0;
         fresh_q <= 1'b0;
         acc_q   <= '0;
         duty_q  <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            integ_q[i] <= '0;
            eprev_q[i] <= '0;
            pmode_q[i] <= '0;
         end
      end else begin
         done_q <= (state_q == ST_WRITE) && last_ch;
         if (tick && (state_q != ST_IDLE)) ovr_q <= 1'b1;
         case (state_q)
            ST_LOAD: begin
               sp_q      <= setpoint[int'(ch_q)*WIDTH +: WIDTH];
               st_q      <= state[int'(ch_q)*WIDTH +: WIDTH];
               kp_q      <= Kp[int'(ch_q)*WIDTH +: WIDTH];
               ki_q      <= Ki[int'(ch_q)*WIDTH +: WIDTH];
               kd_q      <= Kd[int'(ch_q)*WIDTH +: WIDTH];
               pl_q      <= PWMLimit[int'(ch_q)*WIDTH +: WIDTH];
               il_q      <= IntegralLimit[int'(ch_q)*WIDTH +: WIDTH];
               db_q      <= deadband[int'(ch_q)*WIDTH +: WIDTH];
               mode_q    <= mode_in;
               fresh_q   <= !keep_in;
               int_cur_q <= keep_in ? integ_q[ch_q] : '0;
               ep_cur_q  <= keep_in ? eprev_q[ch_q] : '0;
            end
            ST_ERR:   err_q <= err_c[WIDTH-1:0];
            ST_MUL_P: begin
               acc_q     <= prod_ext;
               int_new_q <= int_new_c[WIDTH-1:0];
               deriv_q   <= deriv_c[WIDTH-1:0];
            end
            ST_MUL_I, ST_MUL_D: acc_q <= acc_q + prod_ext;
            ST_SUM:   dnew_q <= dnew_c[WIDTH-1:0];
            ST_WRITE: begin
               duty_q[int'(ch_q)*WIDTH +: WIDTH] <= dnew_q;
               integ_q[ch_q] <= is_pid(mode_q) ? int_new_q : '0;
               eprev_q[ch_q] <= is_pid(mode_q) ? err_q : '0;
               pmode_q[ch_q] <= mode_q;
               ch_q          <= last_ch ? '0 : ch_q + CH_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign duty        = duty_q;
   assign update_done = done_q;
   assign overrun     = ovr_q;

endmodule
